// File: rtl/dsm_cic_decimator.sv
// Receive-side reconstruction filter for the ternary delta-sigma PWM stream:
// symbol decode, 3rd-order CIC decimation by 2^LOG2_DECIM, scaling and saturation.
module dsm_cic_decimator #(
  parameter int LOG2_DECIM = 6,   // legal range 2..8
  parameter int OUT_BITS   = 15
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [1:0]                 pwm_i,
  input  logic                       in_en_i,
  output logic signed [OUT_BITS-1:0] dout_o,
  output logic                       dout_valid_o,
  output logic                       sym_err_o
);

  localparam int W      = 3 * LOG2_DECIM + 2;
  localparam int SHIFT  = 3 * LOG2_DECIM - OUT_BITS + 1;
  localparam int LSHIFT = (SHIFT < 0) ? -SHIFT : 0;
  // Extended width leaves room for a left shift plus a sign bit before clamping.
  localparam int EW     = W + LSHIFT + 1;

  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

  logic signed [W-1:0]        x_d;
  logic                       illegal_d;
  logic                       event_d;
  logic signed [W-1:0]        integ_in [0:2];
  logic signed [W-1:0]        integ_q  [0:2];
  logic signed [W-1:0]        comb_v   [0:3];
  logic signed [W-1:0]        dly_q    [0:2];
  logic [LOG2_DECIM-1:0]      cnt_q;
  logic [1:0]                 warm_q;
  logic signed [EW-1:0]       c3_ext;
  logic signed [EW-1:0]       scaled_d;
  logic signed [OUT_BITS-1:0] sat_d;
  logic signed [OUT_BITS-1:0] dout_q;
  logic                       dout_valid_q;
  logic                       sym_err_q;

  always_comb begin
    x_d       = '0;
    illegal_d = 1'b0;
    case (pwm_i)
      2'b01:   x_d = {{(W-1){1'b0}}, 1'b1};
      2'b11:   x_d = '1;
      2'b10:   illegal_d = 1'b1;
      default: x_d = '0;
    endcase
  end

  // DECIM is a power of two, so the last phase of the counter is all ones.
  assign event_d   = in_en_i && (&cnt_q);
  assign comb_v[0] = integ_q[2];

  // Integrators wrap modulo 2^W on purpose; the combs cancel the wrap.
  for (genvar gi = 0; gi < 3; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign integ_in[gi] = x_d;
    end else begin : g_chain
      assign integ_in[gi] = integ_q[gi-1];
    end

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        integ_q[gi] <= '0;
      end else if (in_en_i) begin
        integ_q[gi] <= integ_q[gi] + integ_in[gi];
      end
    end

    assign comb_v[gi+1] = comb_v[gi] - dly_q[gi];

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        dly_q[gi] <= '0;
      end else if (event_d) begin
        dly_q[gi] <= comb_v[gi];
      end
    end
  end

  assign c3_ext = {{(EW-W){comb_v[3][W-1]}}, comb_v[3]};

  if (SHIFT >= 0) begin : g_shr
    assign scaled_d = c3_ext >>> SHIFT;
  end else begin : g_shl
    assign scaled_d = c3_ext <<< LSHIFT;
  end

  always_comb begin
    if (scaled_d > SAT_MAX) begin
      sat_d = SAT_MAX[OUT_BITS-1:0];
    end else if (scaled_d < SAT_MIN) begin
      sat_d = SAT_MIN[OUT_BITS-1:0];
    end else begin
      sat_d = scaled_d[OUT_BITS-1:0];
    end
  end

  // The first three decimation events only prime the comb delays.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q        <= '0;
      warm_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sym_err_q    <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (in_en_i) begin
        cnt_q <= cnt_q + 1'b1;
        if (illegal_d) begin
          sym_err_q <= 1'b1;
        end
        if (event_d) begin
          if (warm_q != 2'd3) begin
            warm_q <= warm_q + 2'd1;
          end else begin
            dout_q       <= sat_d;
            dout_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign sym_err_o    = sym_err_q;

endmodule
